lemming_world: RTL
==================

// Module: lemming_world
// PURPOSE
//  Terrain/environment model: the driving end of the lemming controller's interface.
//  - Consumes walk_left/walk_right/aaah/digging.
//  - Produces bump_left/bump_right/ground from a per-column floor-depth map.
//  - Tracks lemming position, lowers the floor while digging and flags fatal falls.
//  - Pairs with the controller in closed-loop benches and the top-level demo.
// PARAMETERS
//  WIDTH       16  number of columns, >=2; XW = $clog2(WIDTH)
//  DEPTH       8   rows; floor depth d[c] in 0..DEPTH, DEPTH = bottomless pit; YW = $clog2(DEPTH+1)
//  START_X     8   column loaded into pos_x at reset
//  DIG_CYCLES  4   consecutive digging-on-ground cycles needed to remove one row
//  SPLAT_ROWS  4   landing after more than SPLAT_ROWS rows of fall sets splat
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   synchronous, active-high
//  walk_left   in   1   from lemming controller
//  walk_right  in   1   from lemming controller
//  aaah        in   1   from lemming controller
//  digging     in   1   from lemming controller
//  cfg_we      in   1   terrain write strobe
//  cfg_col     in   XW  column to write
//  cfg_depth   in   YW  new floor depth (values >DEPTH clamp to DEPTH)
//  bump_left   out  1   left neighbour blocked
//  bump_right  out  1   right neighbour blocked
//  ground      out  1   floor directly under lemming
//  pos_x       out  XW  current column
//  pos_y       out  YW  current row (0 = top, grows downward)
//  dig_done    out  1   one-cycle pulse: a row was removed
//  splat       out  1   sticky: fatal fall occurred
// BEHAVIOUR
//  Reset (sync): every d[c]=0; pos_x=START_X; pos_y=0; fall_cnt=0; dig_cnt=0; splat=0; dig_done=0.
//   Hence ground=1 and bump_left=bump_right=0 after reset; pos_x=0 or WIDTH-1 gives bump_left=1 or bump_right=1.
//  Outputs are functions of registered state only; no combinational path from inputs.
//  Decoding of inputs:
//   - Lemming outputs are sampled each clk.
//   - Priority: aaah > digging > walk.
//   - Both walk_left and walk_right high with digging=0 and aaah=0: hold position.
//  Combinational outputs:
//   - ground     = (d[pos_x]==pos_y) && (d[pos_x]!=DEPTH)
//   - bump_left  = (pos_x==0)       || (d[pos_x-1] < pos_y)   (higher floor acts as wall)
//   - bump_right = (pos_x==WIDTH-1) || (d[pos_x+1] < pos_y)
//  Walk: ground && walk_left && !bump_left -> pos_x-1; mirror for walk_right/bump_right.
//   - Blocked walks do not move; the lemming turns by itself.
//   - Stepping onto a deeper column makes ground=0 on the next cycle.
//  Fall (ground==0, regardless of aaah):
//   - pos_y+1 per cycle until pos_y==d[pos_x]; fall_cnt+1 per row.
//   - Pit: pos_y saturates at DEPTH; ground stays 0; splat is not set.
//   - Landing cycle: fall_cnt+1 > SPLAT_ROWS -> splat<=1 (sticky until reset).
//   - fall_cnt clears on any cycle with ground==1.
//  Dig (ground && digging):
//   - dig_cnt+1 each cycle.
//   - At dig_cnt==DIG_CYCLES-1: d[pos_x]+1, dig_cnt<=0, dig_done pulses 1 cycle.
//   - pos_y is unchanged, so ground drops to 0 next cycle and the lemming falls.
//   - Digging at d==DEPTH-1 makes the column a pit.
//   - dig_cnt clears whenever digging==0 or ground==0.
//  Config: cfg_we writes d[cfg_col] at the clock edge, any time.
//   - Writes to pos_x affect ground/bump from the next cycle.
//   - cfg write and dig increment on the same column in the same cycle: the cfg write wins, dig_cnt<=0, no dig_done.
//   - cfg_col >= WIDTH: the write is ignored.
//  Reset mid-fall or mid-dig: all state returns to reset values on the next edge.
// CONFIGURATION
//  LEMMING_WORLD_WRAP_EN defined:
//   - Columns form a ring; edges are not walls.
//   - Neighbour of 0 is WIDTH-1 and vice versa.
//   - Left walk from 0 lands on WIDTH-1.
//   - bump_* uses only the depth comparison on the wrapped neighbour.
//  Not defined: edge columns are hard walls as above; pos_x never wraps.
// TESTING
//  1. Reset, walk_left=1 for 8 cycles -> pos_x 8..0; at pos_x=0, bump_left=1 and pos_x holds.
//  2. d[5]=3 via cfg, lemming at x=6 walks left -> pos_x=5, ground=0; pos_y 1,2,3 in 3 cycles; ground=1; splat=0.
//  3. digging=1 on ground at x=8, DIG_CYCLES=4 -> dig_done pulses on cycle 4, d[8]=1; next cycle ground=0; pos_y=1 a cycle later.
//  4. d[3]=6 (>SPLAT_ROWS), lemming walks in from x=4 -> lands at pos_y=6 with splat=1; splat stays 1 until reset.
//  5. d[2]=DEPTH, walk in -> pos_y saturates at 8, ground stays 0, splat=0; reset -> pos_x=8, pos_y=0, ground=1.
//  6. WRAP_EN build: at pos_x=0 walk_left -> pos_x=15, bump_left=0; non-WRAP build -> bump_left=1, pos_x=0.

Source files
------------

// File: rtl/lemming_world_if.sv
// Signal bundle between the terrain model (slave) and the lemming controller or bench (master),
// plus the terrain configuration write port.
interface lemming_world_if #(
    parameter int XW = 4,
    parameter int YW = 4
);
    logic          walk_left;
    logic          walk_right;
    logic          aaah;
    logic          digging;
    logic          cfg_we;
    logic [XW-1:0] cfg_col;
    logic [YW-1:0] cfg_depth;
    logic          bump_left;
    logic          bump_right;
    logic          ground;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;
    logic          dig_done;
    logic          splat;

    modport master (
        output walk_left, walk_right, aaah, digging, cfg_we, cfg_col, cfg_depth,
        input  bump_left, bump_right, ground, pos_x, pos_y, dig_done, splat
    );

    modport slave (
        input  walk_left, walk_right, aaah, digging, cfg_we, cfg_col, cfg_depth,
        output bump_left, bump_right, ground, pos_x, pos_y, dig_done, splat
    );
endinterface

// File: rtl/lemming_world.sv
// Terrain model for the lemming controller: per-column floor depths, lemming position, digging and falls.
// Define LEMMING_WORLD_WRAP_EN to join the edge columns into a ring instead of treating them as walls.
module lemming_world #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 8,
    parameter int START_X    = 8,
    parameter int DIG_CYCLES = 4,
    parameter int SPLAT_ROWS = 4,
    localparam int XW        = $clog2(WIDTH),
    localparam int YW        = $clog2(DEPTH + 1)
) (
    input logic              clk,
    input logic              reset,
    lemming_world_if.slave   bus
);
    localparam int DCW = (DIG_CYCLES > 1) ? $clog2(DIG_CYCLES) : 1;
    localparam logic [XW-1:0]  LAST_X    = XW'(WIDTH - 1);
    localparam logic [YW-1:0]  PIT       = YW'(DEPTH);
    localparam logic [YW-1:0]  SPLAT_LIM = YW'(SPLAT_ROWS);
    localparam logic [DCW-1:0] DIG_LAST  = DCW'(DIG_CYCLES - 1);

    logic [YW-1:0]  d_q [WIDTH];
    logic [YW-1:0]  d_d [WIDTH];
    logic [XW-1:0]  pos_x_q, pos_x_d;
    logic [YW-1:0]  pos_y_q, pos_y_d;
    logic [YW-1:0]  fall_cnt_q, fall_cnt_d;
    logic [DCW-1:0] dig_cnt_q, dig_cnt_d;
    logic           splat_q, splat_d;
    logic           dig_done_q, dig_done_d;

    logic [XW-1:0]  left_x, right_x;
    logic [YW-1:0]  cur_depth;
    logic [YW-1:0]  cfg_depth_clamped;
    logic           ground, bump_left, bump_right;
    logic           at_left_edge, at_right_edge;
    logic           cfg_col_ok, cfg_hits_here;

    assign left_x    = (pos_x_q == '0)     ? LAST_X : pos_x_q - 1'b1;
    assign right_x   = (pos_x_q == LAST_X) ? '0     : pos_x_q + 1'b1;
    assign cur_depth = d_q[pos_x_q];

`ifdef LEMMING_WORLD_WRAP_EN
    assign at_left_edge  = 1'b0;
    assign at_right_edge = 1'b0;
`else
    assign at_left_edge  = (pos_x_q == '0);
    assign at_right_edge = (pos_x_q == LAST_X);
`endif

    // A neighbouring column whose floor is above the lemming's row acts as a wall.
    assign ground     = (cur_depth == pos_y_q) && (cur_depth != PIT);
    assign bump_left  = at_left_edge  || (d_q[left_x]  < pos_y_q);
    assign bump_right = at_right_edge || (d_q[right_x] < pos_y_q);

    if (WIDTH == (1 << XW)) begin : g_cfg_full
        assign cfg_col_ok = 1'b1;
    end else begin : g_cfg_part
        assign cfg_col_ok = (bus.cfg_col <= LAST_X);
    end

    assign cfg_depth_clamped = (bus.cfg_depth > PIT) ? PIT : bus.cfg_depth;
    assign cfg_hits_here     = bus.cfg_we && cfg_col_ok && (bus.cfg_col == pos_x_q);

    // Falling overrides everything; on ground, aaah blocks digging and digging blocks walking.
    always_comb begin
        d_d        = d_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        fall_cnt_d = fall_cnt_q;
        dig_cnt_d  = '0;
        splat_d    = splat_q;
        dig_done_d = 1'b0;

        if (!ground) begin
            if (pos_y_q < cur_depth) begin
                pos_y_d    = pos_y_q + 1'b1;
                fall_cnt_d = fall_cnt_q + 1'b1;
                if ((pos_y_d == cur_depth) && (cur_depth != PIT) && (fall_cnt_d > SPLAT_LIM)) begin
                    splat_d = 1'b1;
                end
            end
        end else begin
            fall_cnt_d = '0;
            if (!bus.aaah) begin
                if (bus.digging) begin
                    if (dig_cnt_q == DIG_LAST) begin
                        if (!cfg_hits_here) begin
                            d_d[pos_x_q] = cur_depth + 1'b1;
                            dig_done_d   = 1'b1;
                        end
                    end else begin
                        dig_cnt_d = dig_cnt_q + 1'b1;
                    end
                end else if (bus.walk_left && !bus.walk_right && !bump_left) begin
                    pos_x_d = left_x;
                end else if (bus.walk_right && !bus.walk_left && !bump_right) begin
                    pos_x_d = right_x;
                end
            end
        end

        if (bus.cfg_we && cfg_col_ok) begin
            d_d[bus.cfg_col] = cfg_depth_clamped;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < WIDTH; c++) begin
                d_q[c] <= '0;
            end
            pos_x_q    <= XW'(START_X);
            pos_y_q    <= '0;
            fall_cnt_q <= '0;
            dig_cnt_q  <= '0;
            splat_q    <= 1'b0;
            dig_done_q <= 1'b0;
        end else begin
            d_q        <= d_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            fall_cnt_q <= fall_cnt_d;
            dig_cnt_q  <= dig_cnt_d;
            splat_q    <= splat_d;
            dig_done_q <= dig_done_d;
        end
    end

    assign bus.bump_left  = bump_left;
    assign bus.bump_right = bump_right;
    assign bus.ground     = ground;
    assign bus.pos_x      = pos_x_q;
    assign bus.pos_y      = pos_y_q;
    assign bus.dig_done   = dig_done_q;
    assign bus.splat      = splat_q;
endmodule
